// File: rtl/obj_arb_pkg.sv
// ---------------------------------------------------------------------------
// obj_arb_pkg
// Shared types and constants for the object-state RAM arbiter.
//   state_t          : arbiter phase (RENDER / UPDATE)
//   REQ_*            : requester slot indices
//   DEF_NREQ/AW/DW   : default requester count, address and data widths
// ---------------------------------------------------------------------------
package obj_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 6;
  localparam int DEF_DW   = 16;

  localparam int REQ_RENDER = 0;
  localparam int REQ_PLAYER = 1;
  localparam int REQ_ENEMY  = 2;
  localparam int REQ_BULLET = 3;

  typedef enum logic {
    RENDER = 1'b0,
    UPDATE = 1'b1
  } state_t;

endpackage

// File: rtl/obj_ram_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker over an N-entry request field.
// The search starts one slot after i_ptr and wraps within 0..N-1.
// Ports:
//   i_req   [N-1:0]  request field
//   i_ptr   [PW-1:0] last-served slot
//   o_gnt   [N-1:0]  one-hot pick (zero when nothing requested)
//   o_idx   [PW-1:0] encoded pick
//   o_valid          any pick made
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    // Offsets 1..N visit every slot once, the last-served slot last.
    for (int off = 1; off <= N; off++) begin
      if (!o_valid && i_req[(int'(i_ptr) + off) % N]) begin
        o_valid = 1'b1;
        o_gnt[(int'(i_ptr) + off) % N] = 1'b1;
        o_idx = PW'((int'(i_ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/obj_ram_arbiter.sv
// ---------------------------------------------------------------------------
// obj_ram_arbiter
// Shares the single-port synchronous object-state RAM between the renderer
// (requester 0, always top priority) and the game-logic updaters
// (requesters 1..NREQ-1, served round-robin only during vertical blank).
// Also emits frame_start, the per-frame update kick, at vblank entry.
//
// Handshake: a requester raises req[i] (with we/addr/wdata) and holds it
// until the cycle gnt[i] is high; that cycle is the transfer. It may raise
// req again in the very next cycle. Read data returns two cycles after the
// grant as rvalid[i] with rdata; writes return nothing.
//
// Ports:
//   clk, reset (sync, active-high), vblank
//   req/we [NREQ], addr [NREQ*AW], wdata [NREQ*DW]   requester side
//   gnt/rvalid [NREQ], rdata [DW]                    requester responses
//   mem_addr/mem_we/mem_wdata (registered), mem_rdata RAM side
//   frame_start                                      one-cycle pulse
//   miss_cnt [8]   frames ending with an updater still waiting
//   dbg_state      current arbiter phase
//
// Build option: define OBJ_ARB_MISS_CNT_EN to build the miss counter;
// otherwise miss_cnt is tied to zero.
// ---------------------------------------------------------------------------
module obj_ram_arbiter
  import obj_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vblank,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               frame_start,
  output logic [7:0]         miss_cnt,
  output state_t             dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int NU = NREQ - 1;
  localparam int PW = (NU > 1) ? $clog2(NU) : 1;

  state_t            r_state;
  logic              r_vblank_q;
  logic [IW-1:0]     r_rr_ptr;
  logic [AW-1:0]     r_mem_addr;
  logic              r_mem_we;
  logic [DW-1:0]     r_mem_wdata;
  logic [NREQ-1:0]   r_rd_stage;
  logic [NREQ-1:0]   r_rvalid;
  logic              r_frame_start;

  logic [NU-1:0]     w_pick_gnt;
  logic [PW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic [PW-1:0]     w_pick_ptr;
  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_gnt_any;
  logic              w_vb_rise;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  logic              w_sel_we;

  assign w_vb_rise = vblank & ~r_vblank_q;

  // rr_ptr holds an updater index 1..NREQ-1; the picker works on the
  // updater field alone, so shift the pointer down by one.
  assign w_pick_ptr = PW'(r_rr_ptr - IW'(1));

  rr_pick #(.N(NU)) u_rr_pick (
    .i_req   (req[NREQ-1:1]),
    .i_ptr   (w_pick_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (!reset) begin
      if (req[REQ_RENDER]) begin
        w_gnt[REQ_RENDER] = 1'b1;
        w_gnt_any         = 1'b1;
      end else if (r_state == UPDATE && w_pick_valid) begin
        w_gnt     = {w_pick_gnt, 1'b0};
        w_gnt_idx = IW'(w_pick_idx) + IW'(1);
        w_gnt_any = 1'b1;
      end
    end
  end

  assign w_sel_addr  = addr[int'(w_gnt_idx)*AW +: AW];
  assign w_sel_wdata = wdata[int'(w_gnt_idx)*DW +: DW];
  // The renderer only ever reads; its write enable is dropped here.
  assign w_sel_we    = we[w_gnt_idx] & (w_gnt_idx != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RENDER;
      r_vblank_q    <= 1'b0;
      r_rr_ptr      <= IW'(NREQ - 1);
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_wdata   <= '0;
      r_rd_stage    <= '0;
      r_rvalid      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_vblank_q    <= vblank;
      r_frame_start <= w_vb_rise;

      case (r_state)
        RENDER: if (w_vb_rise) r_state <= UPDATE;
        UPDATE: if (!vblank)   r_state <= RENDER;
        default:               r_state <= RENDER;
      endcase

      if (w_gnt_any) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_we    <= w_sel_we;
        if (w_gnt_idx != '0) r_rr_ptr <= w_gnt_idx;
      end else begin
        r_mem_we <= 1'b0;
      end

      // Stage 1 tracks the address cycle, stage 2 the RAM data cycle.
      r_rd_stage <= (w_gnt_any && !w_sel_we) ? w_gnt : '0;
      r_rvalid   <= r_rd_stage;
    end
  end

`ifdef OBJ_ARB_MISS_CNT_EN
  logic [7:0] r_miss_cnt;
  logic       w_upd_req;

  assign w_upd_req = |req[NREQ-1:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss_cnt <= '0;
    end else if (r_state == UPDATE && !vblank && w_upd_req &&
                 r_miss_cnt != 8'hFF) begin
      r_miss_cnt <= r_miss_cnt + 8'd1;
    end
  end

  assign miss_cnt = r_miss_cnt;
`else
  assign miss_cnt = '0;
`endif

  assign gnt         = w_gnt;
  assign rvalid      = r_rvalid;
  assign rdata       = mem_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign frame_start = r_frame_start;
  assign dbg_state   = r_state;

endmodule
